// File: rtl/franken_pkg.sv
// ---------------------------------------------------------------------------
// franken_pkg
// Shared constants for the Franken RISC-V unified-memory arbiter.
//   - FSM state encodings (IDLE / HOLD / WAIT)
//   - owner encodings for the two requesters (fetch port, data port)
//   - the byte-enable pattern used for instruction fetches
// ---------------------------------------------------------------------------
package franken_pkg;

    // Arbiter FSM states
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    // Which requester owns the current transaction
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Instruction fetches always read a full 32-bit word
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage : franken_pkg

// File: rtl/franken_rr_arb2.sv
// ---------------------------------------------------------------------------
// franken_rr_arb2
// Two-way round-robin picker. With a single requester it simply selects
// that requester; on a tie it selects the one that was not granted last.
//
// Ports:
//   req        in  [1:0]  request vector, bit 0 = fetch port, bit 1 = data port
//   last_grant in  1      owner of the most recently accepted transaction
//   grant      out [1:0]  one-hot grant (all zero when nobody requests)
// ---------------------------------------------------------------------------
module franken_rr_arb2
    import franken_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // On a tie, favour whoever did not win last time so neither port starves.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == OWN_IF) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule : franken_rr_arb2

// File: rtl/franken_mem_arbiter.sv
// ---------------------------------------------------------------------------
// franken_mem_arbiter
// Shares one single-port memory between the core's instruction-fetch port
// and its load/store data port. One transaction may be outstanding at a
// time; each waits at most TIMEOUT cycles for its response before an error
// response is forced back to the owning requester.
//
// Parameters:
//   AW       address width
//   DW       data width (byte enables are DW/8 wide, DW a multiple of 32)
//   TIMEOUT  WAIT cycles before an error response is generated (1..255)
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   if_req/if_addr             fetch request (read only)
//   if_ready                   fetch request accepted this cycle (comb)
//   if_rvalid/if_rdata/if_err  fetch response pulse, data, timeout flag
//   d_req/d_we/d_be/d_addr/d_wdata   load/store request
//   d_ready                    data request accepted this cycle (comb)
//   d_rvalid/d_rdata/d_err     load data or store ack pulse, timeout flag
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata   request to memory
//   mem_ready                  memory accepts the request this cycle
//   mem_rvalid/mem_rdata       memory response
// ---------------------------------------------------------------------------
module franken_mem_arbiter
    import franken_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
)
(
    input  logic            clk,
    input  logic            reset,

    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_ready,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    output logic            if_err,

    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_ready,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            d_err,

    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int              BW       = DW / 8;
    localparam logic [BW-1:0]   FETCH_BE = {(BW / 4){BE_WORD}};
    localparam logic [7:0]      TO_LIMIT = 8'(TIMEOUT);

    logic [1:0]    state;
    logic          owner;
    logic          last_grant;
    logic [7:0]    cnt;
    logic [7:0]    cnt_inc;
    logic          timeout_hit;

    // Request fields captured when the memory stalls, so the bus stays
    // stable in HOLD regardless of what the requester does meanwhile.
    logic          hold_we;
    logic [BW-1:0] hold_be;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_wdata;

    logic [1:0]    grant;
    logic          sel_owner;
    logic          bus_active;
    logic          accept;

    franken_rr_arb2 u_arb (
        .req        ({d_req, if_req}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Decide who is on the bus this cycle: the freshly arbitrated winner in
    // IDLE, the latched owner in HOLD, nobody while waiting for a response.
    always_comb begin
        bus_active = 1'b0;
        sel_owner  = owner;
        case (state)
            IDLE: begin
                bus_active = |grant;
                sel_owner  = grant[1] ? OWN_D : OWN_IF;
            end
            HOLD: begin
                bus_active = 1'b1;
                sel_owner  = owner;
            end
            default: begin
                bus_active = 1'b0;
                sel_owner  = owner;
            end
        endcase
    end

    // Memory request mux. Fields read as zero whenever no request is driven,
    // and the whole bus is forced quiet while reset is held low.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (bus_active && reset) begin
            mem_req = 1'b1;
            if (state == HOLD) begin
                mem_we    = hold_we;
                mem_be    = hold_be;
                mem_addr  = hold_addr;
                mem_wdata = hold_wdata;
            end else if (sel_owner == OWN_D) begin
                mem_we    = d_we;
                mem_be    = d_be;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end else begin
                mem_be    = FETCH_BE;
                mem_addr  = if_addr;
            end
        end
    end

    assign accept      = mem_req & mem_ready;
    assign if_ready    = accept & (sel_owner == OWN_IF);
    assign d_ready     = accept & (sel_owner == OWN_D);

    assign cnt_inc     = cnt + 8'd1;
    assign timeout_hit = (cnt_inc == TO_LIMIT);

    // Main FSM plus response routing. Response pulses default low every
    // cycle; a real memory response always beats a simultaneous timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            last_grant <= OWN_IF;
            cnt        <= '0;
            hold_we    <= 1'b0;
            hold_be    <= '0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            if_rvalid  <= 1'b0;
            if_err     <= 1'b0;
            if_rdata   <= '0;
            d_rvalid   <= 1'b0;
            d_err      <= 1'b0;
            d_rdata    <= '0;
        end else begin
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus_active) begin
                        owner <= sel_owner;
                        if (mem_ready) begin
                            last_grant <= sel_owner;
                            cnt        <= '0;
                            state      <= WAIT;
                        end else begin
                            hold_we    <= mem_we;
                            hold_be    <= mem_be;
                            hold_addr  <= mem_addr;
                            hold_wdata <= mem_wdata;
                            state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (mem_ready) begin
                        last_grant <= owner;
                        cnt        <= '0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt_inc;
                    if (mem_rvalid || timeout_hit) begin
                        state <= IDLE;
                        if (owner == OWN_D) begin
                            d_rvalid <= 1'b1;
                            d_err    <= ~mem_rvalid;
                            d_rdata  <= mem_rvalid ? mem_rdata : '0;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_err    <= ~mem_rvalid;
                            if_rdata  <= mem_rvalid ? mem_rdata : '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : franken_mem_arbiter

// File: doc/franken_mem_arbiter.md
Name: franken_mem_arbiter

Overview:
- Shares one unified single-port memory between the core's instruction-fetch port and its load/store data port. This is required for the multicycle/pipelined Franken RISC-V variants, where code and data live in a single RAM.
- Provides round-robin arbitration with at most one outstanding transaction, a per-transaction response timeout, and response routing back to the owning requester.
- Sits between the core (pc/instruction, alu_result/write_data/byte_enable/read_data) and the memory/bus model.

Parameters:
- AW, 32, address width
- DW, 32, data width (byte-enable width = DW/8)
- TIMEOUT, 15, cycles in WAIT before an error response is forced (1..255)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request (read only)
- if_addr  in  AW  fetch address (pc)
- if_ready  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch response pulse
- if_rdata  out  DW  fetched instruction
- if_err  out  1  qualifies if_rvalid; timeout occurred
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_be  in  DW/8  byte enables
- d_addr  in  AW  data address (alu_result)
- d_wdata  in  DW  store data (write_data)
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  data response pulse (load data or store ack)
- d_rdata  out  DW  load data
- d_err  out  1  qualifies d_rvalid; timeout occurred
- mem_req  out  1  request to memory
- mem_we  out  1  write strobe
- mem_be  out  DW/8  byte enables (4'b1111 for fetch)
- mem_addr  out  AW  address
- mem_wdata  out  DW  write data (0 for fetch)
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  memory response valid
- mem_rdata  in  DW  memory read data

Behaviour:
- Clock and reset: the design uses one clock, clk. reset is asynchronous and active-low; asserting it low clears all state immediately.
- Reset values:
  - state = IDLE, owner = IF, last_grant = IF, timeout counter = 0.
  - All outputs 0: mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_ready, d_ready, all rvalid/err, all rdata.
- Handshake:
  - A requester holds req and its fields stable until it sees its ready.
  - ready is combinational: it equals mem_req & mem_ready & (owner selected).
  - rvalid and err are registered single-cycle pulses. rdata is valid only with rvalid and holds its last value otherwise.
- FSM states: IDLE, HOLD, WAIT.
  - IDLE:
    - Arbitration is combinational.
    - Only one requester asserting: select it.
    - Both asserting: select the one that is not last_grant. After reset this means DATA wins the first tie.
    - If a requester is selected: drive mem_req = 1 with the selected fields.
    - mem_ready = 1: assert the selected ready, latch owner, set last_grant = owner, clear counter, go to WAIT.
    - mem_ready = 0: latch owner, go to HOLD.
  - HOLD:
    - Keep presenting the latched owner's fields. No re-arbitration, even if the other requester arrives.
    - On mem_ready: assert ready, set last_grant, clear counter, go to WAIT.
  - WAIT:
    - mem_req = 0; the counter increments each cycle.
    - On mem_rvalid: register rdata to the owner and pulse the owner's rvalid with err = 0; go to IDLE.
    - If the counter reaches TIMEOUT with no mem_rvalid: pulse the owner's rvalid with err = 1 and rdata = 0; go to IDLE.
    - mem_rvalid and the timeout in the same cycle: mem_rvalid wins, err = 0.
- Latency:
  - Minimum: the request is accepted in cycle N, mem_rvalid arrives in N+1, and the requester's rvalid goes high in N+2.
  - A new grant is possible in the cycle after the return to IDLE. There are no back-to-back grants in the same cycle as a response.
- Stray responses: mem_rvalid in IDLE or HOLD is ignored, e.g. a late response after a timeout. No requester pulse is generated.
- Fetch fields: mem_we = 0, mem_be = 4'b1111, mem_wdata = 0.
- Data fields: d_we, d_be and d_wdata pass through unchanged. Stores receive d_rvalid as an acknowledge; d_rdata is don't-care for stores (still registered from mem_rdata).
- Reset mid-transaction: return to IDLE immediately with no pulses. A memory response arriving after reset is ignored.
- Requester dropping req while in HOLD: this is a protocol violation. The arbiter keeps the latched owner and fields; this is not checked in RTL and is asserted in the bench.

Decomposition:
- Shared package franken_pkg holds:
  - state encoding: IDLE = 2'd0, HOLD = 2'd1, WAIT = 2'd2
  - owner encoding: OWN_IF = 1'b0, OWN_D = 1'b1
  - the fetch byte-enable constant BE_WORD = 4'b1111
- One natural sub-module, franken_rr_arb2: the 2-way round-robin picker (req vector + last_grant -> one-hot grant).
- The FSM, timeout counter and response routing stay in the top module.

Test Plan:
- Single fetch: if_req = 1, if_addr = 0x0000_0010, mem_ready = 1, mem_rdata = 0x0050_0093 one cycle later -> if_ready pulses in cycle 0, mem_be = 4'hF, mem_we = 0, if_rvalid = 1 with if_rdata = 0x0050_0093 and if_err = 0 in cycle 2.
- Tie after reset, then alternation: if_req = d_req = 1 held, immediate memory -> grant order D, IF, D, IF. d_addr = 0x100 and if_addr = 0x4 alternate on mem_addr.
- Store with stall: d_req = 1, d_we = 1, d_be = 4'b0100, d_wdata = 0x0055_0000, mem_ready low for 3 cycles -> state HOLD, mem fields stable, late if_req not granted. d_ready pulses on the cycle mem_ready rises; d_rvalid ack follows mem_rvalid.
- Timeout: TIMEOUT = 15, fetch accepted, mem_rvalid never returns -> exactly 15 cycles in WAIT, then if_rvalid = 1, if_err = 1, if_rdata = 0. A late mem_rvalid in IDLE produces no pulse.
- Boundary: mem_rvalid arrives on the same cycle the counter hits 15 -> normal response, err = 0.
- Async reset: drop reset low during WAIT, mid-cycle -> all outputs 0 immediately. After release, a tie grants D first.
